// File: rtl/quadra_collect.sv
// quadra_collect: credit-controlled result FIFO behind the quadratic evaluator.
// Define QUADRA_COLLECT_MINMAX_EN to add the running y_min / y_max registers.
module quadra_collect #(
   parameter int Y_W   = 20,
   parameter int LAT   = 1,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_b,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [Y_W-1:0]             y,
   input  logic                       clr,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [Y_W-1:0]             out_data,
   output logic [$clog2(DEPTH+1)-1:0] count
`ifdef QUADRA_COLLECT_MINMAX_EN
   ,
   output logic [Y_W-1:0]             y_min,
   output logic [Y_W-1:0]             y_max
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam int IW = $clog2(LAT+1);

   logic           acc;
   logic           land;
   logic           wr;
   logic           rd;
   logic [LAT-1:0] vsr;
   logic [IW-1:0]  infl;
   logic [AW-1:0]  wptr;
   logic [AW-1:0]  rptr;
   logic [CW:0]    occ;
   logic [Y_W-1:0] mem [DEPTH];

   // Credits cover both stored entries and results still inside the evaluator
   assign occ       = (CW+1)'(count) + (CW+1)'(infl);
   assign in_ready  = occ < (CW+1)'(DEPTH);
   assign acc       = in_valid & in_ready;
   assign land      = vsr[LAT-1];
   assign out_valid = count != '0;
   assign wr        = land & ~clr;
   assign rd        = out_valid & out_ready & ~clr;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         vsr  <= '0;
         infl <= '0;
      end else if (clr) begin
         vsr  <= '0;
         infl <= '0;
      end else begin
         vsr[0] <= acc;
         for (int i = 1; i < LAT; i++)
            vsr[i] <= vsr[i-1];
         if (acc & ~land)
            infl <= infl + IW'(1);
         else if (land & ~acc)
            infl <= infl - IW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (wr)
         mem[wptr] <= y;
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         out_data <= '0;
      end else if (clr) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         out_data <= '0;
      end else begin
         if (wr)
            wptr <= wptr + AW'(1);
         if (rd)
            rptr <= rptr + AW'(1);
         if (wr & ~rd)
            count <= count + CW'(1);
         else if (rd & ~wr)
            count <= count - CW'(1);
         // Head register: next entry is in mem unless it is the one arriving now
         if (rd) begin
            if (count != CW'(1))
               out_data <= mem[rptr + AW'(1)];
            else if (wr)
               out_data <= y;
         end else if (wr && count == '0) begin
            out_data <= y;
         end
      end
   end

`ifdef QUADRA_COLLECT_MINMAX_EN
   localparam logic [Y_W-1:0] MAXP = {1'b0, {(Y_W-1){1'b1}}};
   localparam logic [Y_W-1:0] MINN = {1'b1, {(Y_W-1){1'b0}}};

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         y_min <= MAXP;
         y_max <= MINN;
      end else if (clr) begin
         y_min <= MAXP;
         y_max <= MINN;
      end else if (wr) begin
         if ($signed(y) < $signed(y_min))
            y_min <= y;
         if ($signed(y) > $signed(y_max))
            y_max <= y;
      end
   end
`endif

endmodule

// File: tb/tb_quadra_collect.sv
// tb_quadra_collect: random and directed stimulus against a queue model.
// Define QUADRA_COLLECT_MINMAX_EN to also check y_min / y_max.
module tb_quadra_collect;

   localparam int Y_W   = 20;
   localparam int LAT   = 1;
   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH+1);

   typedef logic [Y_W-1:0] yv_t;
   typedef struct {
      int unsigned at;
      yv_t         v;
   } fl_t;

   localparam yv_t MAXP = {1'b0, {(Y_W-1){1'b1}}};
   localparam yv_t MINN = {1'b1, {(Y_W-1){1'b0}}};

   logic          clk = 1'b0;
   logic          rst_b = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          clr = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   yv_t           y = '0;
   yv_t           out_data;
   logic [CW-1:0] count;
`ifdef QUADRA_COLLECT_MINMAX_EN
   yv_t           y_min;
   yv_t           y_max;
`endif

   int          checks = 0;
   int          failures = 0;
   int          naccs = 0;
   int unsigned cyc_n = 0;
   yv_t         sb[$];
   fl_t         fq[$];
   yv_t         mn = MAXP;
   yv_t         mx = MINN;

   quadra_collect #(.Y_W(Y_W), .LAT(LAT), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_b     (rst_b),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .y         (y),
      .clr       (clr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .count     (count)
`ifdef QUADRA_COLLECT_MINMAX_EN
      ,
      .y_min     (y_min),
      .y_max     (y_max)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endfunction

   function automatic void mreset();
      sb.delete();
      fq.delete();
      mn = MAXP;
      mx = MINN;
   endfunction

   // Monitor: every handshake at the output pops the oldest expected result
   always @(negedge clk) begin
      if (rst_b && out_valid && out_ready && !clr) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL out_data: got %0h want nothing", out_data);
         end else begin
            chk("out_data", out_data, sb.pop_front());
         end
      end
   end

   task automatic cyc(input logic iv, input logic ordy, input logic cl,
                      input yv_t v, output logic a);
      logic lnd;
      @(posedge clk);
      #1;
      cyc_n++;
      chk("count", 32'(count), sb.size());
      chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
      chk("in_ready", 32'(in_ready), 32'((sb.size() + fq.size()) < DEPTH));
      chk("overflow", 32'(count <= DEPTH), 32'd1);
`ifdef QUADRA_COLLECT_MINMAX_EN
      chk("y_min", 32'(y_min), 32'(mn));
      chk("y_max", 32'(y_max), 32'(mx));
`endif
      lnd = fq.size() != 0 && fq[0].at == cyc_n;
      y = lnd ? fq[0].v : yv_t'($urandom);
      a = iv & in_ready;
      in_valid = iv;
      out_ready = ordy;
      clr = cl;
      if (cl) begin
         mreset();
      end else begin
         if (lnd) begin
            sb.push_back(fq[0].v);
            if ($signed(fq[0].v) < $signed(mn)) mn = fq[0].v;
            if ($signed(fq[0].v) > $signed(mx)) mx = fq[0].v;
            void'(fq.pop_front());
         end
         if (a) begin
            fq.push_back('{cyc_n + LAT, v});
            naccs++;
         end
      end
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      out_ready = 1'b0;
      clr = 1'b0;
      #2;
      rst_b = 1'b0;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_data", 32'(out_data), 32'd0);
`ifdef QUADRA_COLLECT_MINMAX_EN
      chk("rst_y_min", 32'(y_min), 32'(MAXP));
      chk("rst_y_max", 32'(y_max), 32'(MINN));
`endif
      mreset();
      repeat (2) @(posedge clk);
      #1;
      rst_b = 1'b1;
   endtask

   initial begin
      logic a;
      int   v;
      int   k;
      do_reset();

      // Single sample latency
      repeat (3) cyc(1'b0, 1'b1, 1'b0, '0, a);
      cyc(1'b1, 1'b1, 1'b0, 20'h00123, a);
      chk("lat_acc", 32'(a), 32'd1);
      cyc(1'b0, 1'b1, 1'b0, '0, a);
      chk("lat_early", 32'(out_valid), 32'd0);
      cyc(1'b0, 1'b1, 1'b0, '0, a);
      chk("lat_valid", 32'(out_valid), 32'd1);
      chk("lat_data", 32'(out_data), 32'h00123);
      cyc(1'b0, 1'b1, 1'b0, '0, a);
      chk("lat_count", 32'(count), 32'd0);

      // Fill with downstream stalled
      naccs = 0;
      repeat (20) cyc(1'b1, 1'b0, 1'b0, yv_t'($urandom), a);
      chk("fill_accs", naccs, 32'd8);
      chk("fill_count", 32'(count), 32'd8);
      chk("fill_ready", 32'(in_ready), 32'd0);

      // Stream 0..20 through a full FIFO, across pointer wrap
      v = 0;
      k = 0;
      while (v <= 20 && k < 200) begin
         cyc(1'b1, 1'b1, 1'b0, yv_t'(v), a);
         if (a) v++;
         k++;
      end
      chk("stream_done", v, 32'd21);
      repeat (30) cyc(1'b0, 1'b1, 1'b0, '0, a);
      chk("drained", 32'(count), 32'd0);

      // Flush with count=5 and one result in flight
      repeat (6) cyc(1'b1, 1'b0, 1'b0, yv_t'($urandom), a);
      cyc(1'b0, 1'b1, 1'b1, '0, a);
      cyc(1'b0, 1'b1, 1'b0, '0, a);
      chk("clr_count", 32'(count), 32'd0);
      chk("clr_out_valid", 32'(out_valid), 32'd0);
      repeat (4) cyc(1'b0, 1'b1, 1'b0, '0, a);
      chk("clr_noleak", 32'(out_valid), 32'd0);

      // Asynchronous reset with count=3
      repeat (3) cyc(1'b1, 1'b0, 1'b0, yv_t'($urandom), a);
      repeat (2) cyc(1'b0, 1'b0, 1'b0, '0, a);
      chk("pre_rst_count", 32'(count), 32'd3);
      do_reset();

`ifdef QUADRA_COLLECT_MINMAX_EN
      begin
         yv_t mm[4];
         mm[0] = yv_t'(-5);
         mm[1] = yv_t'(7);
         mm[2] = yv_t'(-12);
         mm[3] = yv_t'(3);
         for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, mm[i], a);
         repeat (2) cyc(1'b0, 1'b1, 1'b0, '0, a);
         chk("mm_min", 32'(y_min), 32'(yv_t'(-12)));
         chk("mm_max", 32'(y_max), 32'(yv_t'(7)));
      end
`endif

      // Random traffic with occasional flushes
      repeat (500) begin
         cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
             $urandom_range(0, 40) == 0, yv_t'($urandom), a);
      end
      repeat (30) cyc(1'b0, 1'b1, 1'b0, '0, a);
      chk("final_count", 32'(count), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
